// File: rtl/clock_pkg.sv
// Shared state encoding, field indices and small helpers for the clock-setting controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_t;

    // Field bit positions in inc/dec/blink
    localparam int SEC  = 0;
    localparam int MIN  = 1;
    localparam int HOUR = 2;

    // Button positions inside the conditioner bank
    localparam int BTN_MODE = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;

    // Mode button cycles RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
    function automatic state_t advance_state(input state_t s);
        case (s)
            RUN:      return SET_HOUR;
            SET_HOUR: return SET_MIN;
            SET_MIN:  return SET_SEC;
            default:  return RUN;
        endcase
    endfunction

    // One-hot field being edited in a SET state, zero in RUN
    function automatic logic [2:0] field_mask(input state_t s);
        logic [2:0] m;
        m = 3'b000;
        case (s)
            SET_HOUR: m[HOUR] = 1'b1;
            SET_MIN:  m[MIN]  = 1'b1;
            SET_SEC:  m[SEC]  = 1'b1;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw active-low button -> 2-FF synchronizer -> debounced level -> single-cycle press pulse.
module btn_conditioner #(
    parameter int DEBOUNCE_CYC = 1000000
)(
    input  logic clk50,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC) + 1;

    logic             sync1_reg, sync2_reg;
    logic             level_reg, level_next;
    logic             press_reg, press_next;
    logic             armed_reg, armed_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Synchronizer keeps sampling through reset so the true button level is known at release
    always_ff @(posedge clk50) begin
        sync1_reg <= btn;
        sync2_reg <= sync1_reg;
    end

    // Debounce: accept the new level after DEBOUNCE_CYC consecutive differing samples.
    // A press only counts once the button has been seen released (armed) since reset.
    always_comb begin
        level_next = level_reg;
        press_next = 1'b0;
        cnt_next   = cnt_reg;
        armed_next = armed_reg | (level_reg & sync2_reg);
        if (sync2_reg == level_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYC - 1)) begin
            level_next = sync2_reg;
            cnt_next   = '0;
            press_next = ~sync2_reg & armed_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk50) begin
        if (!reset) begin
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            armed_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            level_reg <= level_next;
            press_reg <= press_next;
            armed_reg <= armed_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock-setting controller: mode FSM, up/down pulses with hold auto-repeat, idle timeout, blink.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int HOLD_CYC     = 25000000,
    parameter int REPEAT_CYC   = 5000000,
    parameter int TIMEOUT_SEC  = 10
)(
    input  logic       clk50,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       tick_1hz,
    output logic [2:0] inc,
    output logic [2:0] dec,
    output logic       count_en,
    output logic [2:0] blink,
    output logic [1:0] mode
);

    localparam int HOLD_W = $clog2(HOLD_CYC) + 1;
    localparam int REP_W  = $clog2(REPEAT_CYC) + 1;
    localparam int RPT_W  = (HOLD_W > REP_W) ? HOLD_W : REP_W;
    localparam int IDLE_W = $clog2(TIMEOUT_SEC) + 1;

    logic [2:0] btn_raw, btn_level, btn_press;
    logic       held_up, held_down, held_any, both_held;
    logic       ev_up, ev_down;

    state_t            state_reg, state_next;
    logic [RPT_W-1:0]  rpt_cnt_reg, rpt_cnt_next;
    logic              rpt_active_reg, rpt_active_next;
    logic              rpt_down_reg, rpt_down_next;
    logic              rpt_repeating_reg, rpt_repeating_next;
    logic [IDLE_W-1:0] idle_reg, idle_next;
    logic              phase_reg, phase_next;
    logic [2:0]        inc_reg, inc_next;
    logic [2:0]        dec_reg, dec_next;
    logic [2:0]        blink_reg, blink_next;
    logic              count_en_reg, count_en_next;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            btn_conditioner #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_cond (
                .clk50(clk50),
                .reset(reset),
                .btn  (btn_raw[gi]),
                .level(btn_level[gi]),
                .press(btn_press[gi])
            );
        end
    endgenerate

    assign held_up   = ~btn_level[BTN_UP];
    assign held_down = ~btn_level[BTN_DOWN];
    assign held_any  = ~&btn_level;
    assign both_held = held_up & held_down;

    // Next-state, repeat timing, idle timeout and registered-output values
    always_comb begin
        state_next         = state_reg;
        rpt_cnt_next       = rpt_cnt_reg;
        rpt_active_next    = rpt_active_reg;
        rpt_down_next      = rpt_down_reg;
        rpt_repeating_next = rpt_repeating_reg;
        idle_next          = idle_reg;
        ev_up              = 1'b0;
        ev_down            = 1'b0;
        phase_next         = phase_reg ^ tick_1hz;

        if (state_reg == RUN) begin
            rpt_active_next    = 1'b0;
            rpt_repeating_next = 1'b0;
            rpt_cnt_next       = '0;
            idle_next          = '0;
            if (btn_press[BTN_MODE]) state_next = SET_HOUR;
        end else begin
            if (btn_press[BTN_MODE]) begin
                // Mode wins over any simultaneous up/down activity
                state_next         = advance_state(state_reg);
                rpt_active_next    = 1'b0;
                rpt_repeating_next = 1'b0;
                rpt_cnt_next       = '0;
            end else if (both_held) begin
                rpt_active_next    = 1'b0;
                rpt_repeating_next = 1'b0;
                rpt_cnt_next       = '0;
            end else if (btn_press[BTN_UP]) begin
                ev_up              = 1'b1;
                rpt_active_next    = 1'b1;
                rpt_down_next      = 1'b0;
                rpt_repeating_next = 1'b0;
                rpt_cnt_next       = RPT_W'(1);
            end else if (btn_press[BTN_DOWN]) begin
                ev_down            = 1'b1;
                rpt_active_next    = 1'b1;
                rpt_down_next      = 1'b1;
                rpt_repeating_next = 1'b0;
                rpt_cnt_next       = RPT_W'(1);
            end else if (rpt_active_reg && (rpt_down_reg ? held_down : held_up)) begin
                // Counter holds cycles since the last pulse; first gap is HOLD_CYC, then REPEAT_CYC
                if ((!rpt_repeating_reg && rpt_cnt_reg == RPT_W'(HOLD_CYC)) ||
                    ( rpt_repeating_reg && rpt_cnt_reg == RPT_W'(REPEAT_CYC))) begin
                    ev_up              = ~rpt_down_reg;
                    ev_down            = rpt_down_reg;
                    rpt_repeating_next = 1'b1;
                    rpt_cnt_next       = RPT_W'(1);
                end else begin
                    rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
                end
            end else begin
                rpt_active_next    = 1'b0;
                rpt_repeating_next = 1'b0;
                rpt_cnt_next       = '0;
            end

            // Idle timer: a user pressing or holding any key is not idle
            if ((|btn_press) || ev_up || ev_down || held_any) begin
                idle_next = '0;
            end else if (tick_1hz) begin
                if (idle_reg == IDLE_W'(TIMEOUT_SEC - 1)) begin
                    state_next = RUN;
                    idle_next  = '0;
                end else begin
                    idle_next = idle_reg + IDLE_W'(1);
                end
            end
        end

        inc_next      = ev_up   ? field_mask(state_reg) : 3'b000;
        dec_next      = ev_down ? field_mask(state_reg) : 3'b000;
        count_en_next = (state_next == RUN);
        blink_next    = field_mask(state_next) & {3{phase_next}};
    end

    // State and output registers
    always_ff @(posedge clk50) begin
        if (!reset) begin
            state_reg         <= RUN;
            rpt_cnt_reg       <= '0;
            rpt_active_reg    <= 1'b0;
            rpt_down_reg      <= 1'b0;
            rpt_repeating_reg <= 1'b0;
            idle_reg          <= '0;
            phase_reg         <= 1'b0;
            inc_reg           <= 3'b000;
            dec_reg           <= 3'b000;
            blink_reg         <= 3'b000;
            count_en_reg      <= 1'b1;
        end else begin
            state_reg         <= state_next;
            rpt_cnt_reg       <= rpt_cnt_next;
            rpt_active_reg    <= rpt_active_next;
            rpt_down_reg      <= rpt_down_next;
            rpt_repeating_reg <= rpt_repeating_next;
            idle_reg          <= idle_next;
            phase_reg         <= phase_next;
            inc_reg           <= inc_next;
            dec_reg           <= dec_next;
            blink_reg         <= blink_next;
            count_en_reg      <= count_en_next;
        end
    end

    assign inc      = inc_reg;
    assign dec      = dec_reg;
    assign blink    = blink_reg;
    assign count_en = count_en_reg;
    assign mode     = state_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/hold/repeat/timeout parameters.
module tb_clock_set_ctrl;

    logic       clk50 = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b1;
    logic       btn_up = 1'b1;
    logic       btn_down = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [2:0] inc, dec, blink;
    logic       count_en;
    logic [1:0] mode;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit bm, bu, bd;
        int ncyc;
        bit chk_state;
        int exp_mode;
        bit exp_cen;
        int exp_inc;
        int exp_dec;
    } vec_t;

    vec_t vq[$];

    clock_set_ctrl #(
        .DEBOUNCE_CYC(4),
        .HOLD_CYC    (20),
        .REPEAT_CYC  (5),
        .TIMEOUT_SEC (3)
    ) dut (
        .clk50   (clk50),
        .reset   (reset),
        .btn_mode(btn_mode),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .tick_1hz(tick_1hz),
        .inc     (inc),
        .dec     (dec),
        .count_en(count_en),
        .blink   (blink),
        .mode    (mode)
    );

    always #5 clk50 = ~clk50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n, output int ni, output int nd);
        ni = 0;
        nd = 0;
        repeat (n) begin
            @(posedge clk50);
            #1;
            if (inc != 3'b000) ni++;
            if (dec != 3'b000) nd++;
        end
    endtask

    task automatic press_mode(output int ni, output int nd);
        int a, b;
        btn_mode = 1'b0;
        step(6, ni, nd);
        btn_mode = 1'b1;
        step(10, a, b);
        ni += a;
        nd += b;
    endtask

    task automatic add(input bit bm, bu, bd, input int n, input bit cs,
                       input int m, input bit c, input int i, input int d);
        vec_t v;
        v.bm = bm; v.bu = bu; v.bd = bd; v.ncyc = n; v.chk_state = cs;
        v.exp_mode = m; v.exp_cen = c; v.exp_inc = i; v.exp_dec = d;
        vq.push_back(v);
    endtask

    // Output sanity every cycle: inc/dec at most one-hot and never together
    always @(posedge clk50) begin
        #1;
        checks++;
        if (!$onehot0(inc) || !$onehot0(dec) || ((inc != 3'b000) && (dec != 3'b000))) begin
            errors++;
            $display("FAIL onehot: got inc=%b dec=%b required one-hot-or-zero, exclusive", inc, dec);
        end
    end

    initial begin
        int   ni, nd, nd_a, exp_phase;
        int   pk[$];
        int   exp_k[5];
        vec_t v;

        //   bm bu bd ncyc chk mode cen inc dec
        add(0, 1, 1,  6, 0, 0, 1, 0, 0);  // mode press
        add(1, 1, 1, 10, 1, 1, 0, 0, 0);  // -> SET_HOUR
        add(0, 1, 1,  6, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 2, 0, 0, 0);  // -> SET_MIN
        add(0, 1, 1,  6, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 3, 0, 0, 0);  // -> SET_SEC
        add(0, 1, 1,  6, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 0, 1, 0, 0);  // -> RUN
        add(1, 0, 1,  6, 0, 0, 0, 0, 0);  // up in RUN is ignored
        add(1, 1, 1, 10, 1, 0, 1, 0, 0);
        add(0, 1, 1,  6, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 1, 0, 0, 0);  // -> SET_HOUR
        add(1, 0, 1,  6, 0, 0, 0, 0, 0);  // up press, pulse lands after window
        add(1, 1, 1, 10, 1, 1, 0, 1, 0);
        add(1, 1, 0,  6, 0, 0, 0, 0, 0);  // down press
        add(1, 1, 1, 10, 1, 1, 0, 0, 1);
        add(1, 1, 0,  2, 0, 0, 0, 0, 0);  // 2-cycle glitch
        add(1, 1, 1, 10, 1, 1, 0, 0, 0);
        add(1, 0, 0, 30, 1, 1, 0, 0, 0);  // up+down together
        add(1, 1, 1, 10, 1, 1, 0, 0, 0);
        add(0, 1, 1,  6, 0, 0, 0, 0, 0);
        add(1, 1, 1, 10, 1, 2, 0, 0, 0);  // -> SET_MIN

        // Reset state
        reset = 1'b0;
        repeat (4) @(posedge clk50);
        #1;
        chk("rst_mode", int'(mode), 0);
        chk("rst_count_en", int'(count_en), 1);
        chk("rst_inc", int'(inc), 0);
        chk("rst_dec", int'(dec), 0);
        chk("rst_blink", int'(blink), 0);
        $display("reset: mode=%0d count_en=%0d inc=%b dec=%b blink=%b", mode, count_en, inc, dec, blink);
        reset = 1'b1;

        foreach (vq[i]) begin
            v = vq[i];
            btn_mode = v.bm;
            btn_up   = v.bu;
            btn_down = v.bd;
            step(v.ncyc, ni, nd);
            if (v.chk_state) begin
                chk($sformatf("vec%0d_mode", i), int'(mode), v.exp_mode);
                chk($sformatf("vec%0d_count_en", i), int'(count_en), int'(v.exp_cen));
            end
            chk($sformatf("vec%0d_inc_n", i), ni, v.exp_inc);
            chk($sformatf("vec%0d_dec_n", i), nd, v.exp_dec);
            $display("vec %0d: btn=%b%b%b cyc=%0d mode=%0d count_en=%0d inc_n=%0d dec_n=%0d",
                     i, v.bm, v.bu, v.bd, v.ncyc, mode, count_en, ni, nd);
        end
        btn_mode = 1'b1; btn_up = 1'b1; btn_down = 1'b1;

        // Hold-up auto-repeat in SET_MIN: 40 cycles low
        exp_k = '{6, 26, 31, 36, 41};
        nd_a = 0;
        btn_up = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk50);
            #1;
            if (inc != 3'b000) begin
                pk.push_back(k);
                chk("rep_inc_field", int'(inc), 2);
            end
            if (dec != 3'b000) nd_a++;
            if (k == 39) btn_up = 1'b1;
        end
        chk("rep_count", pk.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rep_time%0d", i), (i < pk.size()) ? pk[i] : -1, exp_k[i]);
        chk("rep_dec", nd_a, 0);
        $display("repeat: inc pulses=%0d dec pulses=%0d", pk.size(), nd_a);

        // Idle timeout in SET_SEC
        press_mode(ni, nd);
        chk("to_sec_mode", int'(mode), 3);
        exp_phase = 0;
        for (int t = 1; t <= 3; t++) begin
            tick_1hz = 1'b1;
            @(posedge clk50);
            #1;
            tick_1hz = 1'b0;
            exp_phase ^= 1;
            if (t < 3) begin
                chk($sformatf("tick%0d_mode", t), int'(mode), 3);
                chk($sformatf("tick%0d_blink", t), int'(blink), exp_phase);
                step(4, ni, nd);
                chk($sformatf("tick%0d_mode_hold", t), int'(mode), 3);
            end else begin
                chk("timeout_mode", int'(mode), 0);
                chk("timeout_count_en", int'(count_en), 1);
                chk("timeout_blink", int'(blink), 0);
            end
            $display("tick %0d: mode=%0d blink=%b", t, mode, blink);
        end

        // Reset while up is held in SET_HOUR
        press_mode(ni, nd);
        chk("rh_mode", int'(mode), 1);
        btn_up = 1'b0;
        step(15, ni, nd);
        chk("rh_first_inc", ni, 1);
        reset = 1'b0;
        step(3, ni, nd);
        chk("rh_inc_in_reset", ni, 0);
        chk("rh_mode_rst", int'(mode), 0);
        chk("rh_count_en_rst", int'(count_en), 1);
        chk("rh_inc_rst", int'(inc), 0);
        chk("rh_dec_rst", int'(dec), 0);
        chk("rh_blink_rst", int'(blink), 0);
        reset = 1'b1;
        press_mode(ni, nd);
        chk("rh_mode_set", int'(mode), 1);
        chk("rh_no_inc_mode", ni, 0);
        step(40, ni, nd);
        chk("rh_no_inc_held", ni, 0);
        btn_up = 1'b1;
        step(10, ni, nd);
        chk("rh_no_inc_release", ni, 0);
        btn_up = 1'b0;
        step(6, ni, nd);
        btn_up = 1'b1;
        step(10, nd_a, nd);
        chk("rh_repress_inc", ni + nd_a, 1);
        $display("reset-hold: mode=%0d inc after re-press=%0d", mode, ni + nd_a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYC, default 1000000, meaning the number of stable clk50 cycles before a button level is accepted.
REQ-002 The block SHALL have parameter HOLD_CYC, default 25000000, meaning the number of held clk50 cycles before auto-repeat starts.
REQ-003 The block SHALL have parameter REPEAT_CYC, default 5000000, meaning the auto-repeat period in clk50 cycles.
REQ-004 The block SHALL have parameter TIMEOUT_SEC, default 10, meaning the number of idle tick_1hz pulses after which the block returns to RUN.
REQ-005 The block SHALL have port clk50, input, 1 bit: the single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port btn_mode, input, 1 bit: raw asynchronous button, active-low (pressed = 0).
REQ-008 The block SHALL have ports btn_up and btn_down, input, 1 bit each: raw asynchronous buttons, active-low.
REQ-009 The block SHALL have port tick_1hz, input, 1 bit: one-cycle pulse once per second.
REQ-010 The block SHALL have port inc, output, 3 bits: one-cycle increment pulse, one-hot per field ([0] = sec, [1] = min, [2] = hour).
REQ-011 The block SHALL have port dec, output, 3 bits: one-cycle decrement pulse, one-hot per field, with the same bit mapping as inc.
REQ-012 The block SHALL have port count_en, output, 1 bit: 1 = timekeeping counters may advance.
REQ-013 The block SHALL have port blink, output, 3 bits: per-field display blank request.
REQ-014 The block SHALL have port mode, output, 2 bits: current state encoding.

Function
REQ-015 Every button SHALL pass through a 2-FF synchronizer, then a debounce counter; the debounced level SHALL change only after DEBOUNCE_CYC consecutive cycles at the new synchronized level.
REQ-016 A press event SHALL be a single-cycle pulse on the debounced 1->0 transition.
REQ-017 The FSM SHALL have states RUN=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
REQ-018 On a mode press, the FSM SHALL advance RUN->SET_HOUR->SET_MIN->SET_SEC->RUN in the next cycle.
REQ-019 count_en SHALL be 1 only in RUN, so time is frozen while setting.
REQ-020 In RUN, inc and dec SHALL be held at 0 and up/down presses SHALL be ignored.
REQ-021 In a SET state, an up press SHALL cause inc[field]=1 for exactly one cycle, one cycle after the press pulse; a down press SHALL do the same on dec[field].
REQ-022 Wrap-around (23->0, 59->0, etc.) SHALL be the field counter's job; this block only emits pulses.
REQ-023 While up (or down) remains debounced-pressed, after HOLD_CYC cycles from the press pulse the block SHALL emit an additional pulse, then one every REPEAT_CYC cycles until release.
REQ-024 If up and down are both debounced-pressed, the block SHALL emit no pulses and SHALL clear the hold/repeat counter; the first key released leaves the other pressed without generating a new press event.
REQ-025 A mode press in the same cycle as an up/down event SHALL take priority: the state advances, no inc/dec is emitted, and the hold counter clears.
REQ-026 The idle counter SHALL count tick_1hz pulses in SET states and SHALL clear on any button press or repeat pulse.
REQ-027 When the idle counter reaches TIMEOUT_SEC, the FSM SHALL go to RUN on the next cycle.
REQ-028 The idle counter SHALL be held at 0 in RUN.
REQ-029 blink[field] SHALL equal the tick_1hz-toggled phase bit in the matching SET state and 0 otherwise.
REQ-030 The phase bit SHALL toggle on each tick_1hz pulse.
REQ-031 All outputs SHALL be registered; inc/dec SHALL never be multi-hot, and inc and dec SHALL never be active in the same cycle.

Reset
REQ-032 While reset=0 at a clk50 edge, the block SHALL set: state=RUN, mode=0, count_en=1, inc=0, dec=0, blink=0, all debounced levels=1 (released), debounce/hold/idle counters=0, phase=0.
REQ-033 Reset asserted mid-hold or mid-SET SHALL abort with no pulse emitted.
REQ-034 Buttons held low through reset release SHALL NOT generate a press event until they are released and pressed again.

Structure
REQ-035 Package clock_pkg SHALL hold the state encoding constants and the field index constants SEC=0, MIN=1, HOUR=2.
REQ-036 Sub-module btn_conditioner (synchronizer + debounce + press pulse, parameter DEBOUNCE_CYC) SHALL be instantiated three times.
REQ-037 The FSM, repeat logic, idle timer and blink logic SHALL be in clock_set_ctrl.
REQ-038 Counter widths SHALL be $clog2 of the corresponding parameter + 1.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=5, TIMEOUT_SEC=3)
REQ-039 Apply mode pulses of 6 cycles low, 4 times -> mode 0->1->2->3->0; count_en=0 only in states 1-3.
REQ-040 In SET_MIN, hold up for 40 cycles -> inc=3'b010 once after press, then at +20, +25, +30, +35 cycles; dec stays 0.
REQ-041 Apply a 2-cycle glitch on btn_down in SET_HOUR -> no dec pulse.
REQ-042 In SET_SEC with no buttons, apply 3 tick_1hz pulses -> mode=0 the cycle after the third tick; blink[0] toggles per tick before that.
REQ-043 Hold up and down together in SET_HOUR for 30 cycles -> inc=dec=0 throughout.
REQ-044 Assert reset while up is held in SET_HOUR -> all outputs at reset values; no inc until up is released and re-pressed.
